cipher_byte_serializer: RTL and testbench

Byte-wide front end for the dual-XOR stream cipher on the TinyTapeout top. It accepts one plaintext byte over a valid/ready handshake and drives the cipher's `tx_p`/`tx_en` pins one bit per strobe, LSB first. It captures the returned `tx_e` bit stream and presents the assembled ciphertext byte on a valid/ready output. It sits between the pad-level `ui_in` byte source and the bit-serial cipher core, which shares this block's clock and reset.

---
 rtl/cipher_pkg.sv | 15 +
 rtl/cipher_bit_collector.sv | 68 ++++++
 rtl/cipher_byte_serializer.sv | 128 ++++++++++++
 tb/tb_cipher_byte_serializer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared types and defaults for the byte-serial front end of the dual-XOR stream cipher.
package cipher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT,
        CAPT,
        OUT
    } ser_state_t;

    localparam int CIPHER_DATA_W_DEF = 8;
    localparam int CIPHER_GAP_DEF    = 1;

endpackage

// File: rtl/cipher_bit_collector.sv
// Gathers the registered cipher return bit into an MSB-in word, one bit per delayed strobe.
// Optional feature macro: CIPHER_SER_PARITY_EN (adds running even parity of the word).
module cipher_bit_collector
    import cipher_pkg::*;
#(
    parameter int DATA_W = CIPHER_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en_i,
    input  logic              tx_e_i,
    input  logic              clr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              word_done_o
`ifdef CIPHER_SER_PARITY_EN
    ,
    output logic              parity_o
`endif
);

    localparam int CW = $clog2(DATA_W + 1);

    logic              cap_q;
    logic [DATA_W-1:0] col_q;
    logic [DATA_W-1:0] col_d;
    logic [CW-1:0]     cnt_q;

    assign col_d = {tx_e_i, col_q[DATA_W-1:1]};

    // NOTE: state is updated with <= so every flop samples pre-edge values,
    // and the reset branch is the synchronous first test inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_q <= 1'b0;
            col_q <= '0;
            cnt_q <= '0;
        end else begin
            cap_q <= tx_en_i;
            if (cap_q) begin
                col_q <= col_d;
            end
            if (clr_i) begin
                cnt_q <= '0;
            end else if (cap_q) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // True on the edge that shifts in the final bit of the word.
    assign word_done_o = cap_q && (cnt_q == CW'(DATA_W - 1));
    assign data_o      = col_q;

`ifdef CIPHER_SER_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (cap_q) begin
            par_q <= ^col_d;
        end
    end

    assign parity_o = par_q;
`endif

endmodule

// File: rtl/cipher_byte_serializer.sv
// Word-to-bit serializer feeding the cipher's tx_p/tx_en pins and reassembling tx_e into a word.
// Optional feature macro: CIPHER_SER_PARITY_EN (adds ct_parity output).
module cipher_byte_serializer
    import cipher_pkg::*;
#(
    parameter int DATA_W = CIPHER_DATA_W_DEF,
    parameter int GAP    = CIPHER_GAP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_p,
    output logic              tx_en,
    input  logic              tx_e,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
`ifdef CIPHER_SER_PARITY_EN
    ,
    output logic              ct_parity
`endif
);

    localparam int            CW       = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    ser_state_t        state_q;
    logic [DATA_W-1:0] sreg_q;
    logic [CW-1:0]     cnt_q;
    logic [3:0]        gap_q;
    logic              tx_p_q;
    logic              tx_en_q;
    logic              out_valid_q;
    logic              accept;
    logic              word_done;

    assign in_ready = rst_n && (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);

    // sreg_q holds the bits not yet presented; tx_p_q is the bit on the wire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            tx_p_q      <= 1'b0;
            tx_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tx_p_q  <= in_data[0];
                        sreg_q  <= in_data >> 1;
                        tx_en_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= CAPT;
                    end else if (GAP > 0) begin
                        gap_q   <= GAP_LAST;
                        state_q <= WAIT;
                    end else begin
                        tx_p_q  <= sreg_q[0];
                        sreg_q  <= sreg_q >> 1;
                        tx_en_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (gap_q == 4'd0) begin
                        tx_p_q  <= sreg_q[0];
                        sreg_q  <= sreg_q >> 1;
                        tx_en_q <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                CAPT: begin
                    // The last return bit lands in the collector on this edge.
                    if (word_done) begin
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_p      = tx_p_q;
    assign tx_en     = tx_en_q;
    assign out_valid = out_valid_q;

    cipher_bit_collector #(
        .DATA_W(DATA_W)
    ) u_collector (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en_i    (tx_en_q),
        .tx_e_i     (tx_e),
        .clr_i      (accept),
        .data_o     (out_data),
        .word_done_o(word_done)
`ifdef CIPHER_SER_PARITY_EN
        ,
        .parity_o   (ct_parity)
`endif
    );

endmodule

// File: tb/tb_cipher_byte_serializer.sv
// Scoreboard bench for cipher_byte_serializer: one GAP=1 and one GAP=0 instance, each with a
// behavioural XOR cipher model; honours CIPHER_SER_PARITY_EN when defined.
module tb_cipher_byte_serializer;

    localparam int DW = 8;
    localparam int NI = 2;

    typedef struct {
        int            s;
        logic [DW-1:0] pt;
        logic [DW-1:0] ct;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n     [NI];
    logic [DW-1:0] in_data   [NI];
    logic          in_valid  [NI];
    logic          in_ready  [NI];
    logic          tx_p      [NI];
    logic          tx_en     [NI];
    logic          tx_e      [NI];
    logic [DW-1:0] out_data  [NI];
    logic          out_valid [NI];
    logic          out_ready [NI];
    logic          busy      [NI];
    logic          k         [NI];
`ifdef CIPHER_SER_PARITY_EN
    logic          ct_parity [NI];
`endif

    cipher_byte_serializer #(.DATA_W(DW), .GAP(1)) dut_g1 (
        .clk(clk), .rst_n(rst_n[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .tx_p(tx_p[0]), .tx_en(tx_en[0]), .tx_e(tx_e[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .busy(busy[0])
`ifdef CIPHER_SER_PARITY_EN
        , .ct_parity(ct_parity[0])
`endif
    );

    cipher_byte_serializer #(.DATA_W(DW), .GAP(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .tx_p(tx_p[1]), .tx_en(tx_en[1]), .tx_e(tx_e[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .busy(busy[1])
`ifdef CIPHER_SER_PARITY_EN
        , .ct_parity(ct_parity[1])
`endif
    );

    // Behavioural cipher: return bit is registered on the edge ending each strobe cycle.
    always @(posedge clk) begin
        for (int s = 0; s < NI; s++) begin
            if (!rst_n[s])     tx_e[s] <= 1'b0;
            else if (tx_en[s]) tx_e[s] <= tx_p[s] ^ k[s];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int gap_of(input int s);
        return (s == 0) ? 1 : 0;
    endfunction

    exp_t          sb [$];
    int            t0       [NI] = '{0, 0};
    int            sidx     [NI] = '{0, 0};
    int            ov_count [NI] = '{0, 0};
    logic          ov_prev  [NI] = '{1'b0, 1'b0};
    logic [DW-1:0] txp_bits [NI] = '{'0, '0};

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        for (int s = 0; s < NI; s++) begin
            exp_t e;
            int   g;
            g = gap_of(s);
            if (!rst_n[s]) sb.delete();
            if (rst_n[s] && in_valid[s] && in_ready[s]) begin
                e.s  = s;
                e.pt = in_data[s];
                e.ct = in_data[s] ^ {DW{k[s]}};
                sb.push_back(e);
                t0[s]   = cyc + 1;
                sidx[s] = 0;
            end
            if (tx_en[s] === 1'b1) begin
                if (sidx[s] >= DW) begin
                    check("strobe_extra", sidx[s], DW - 1);
                end else begin
                    check("strobe_cycle", cyc - t0[s], sidx[s] * (g + 1));
                    txp_bits[s][sidx[s]] = tx_p[s];
                end
                sidx[s]++;
            end
            if (out_valid[s] === 1'b1 && ov_prev[s] !== 1'b1)
                check("out_latency", cyc - t0[s] + 1, DW * (g + 1) - g + 2);
            if (out_valid[s] === 1'b1) ov_count[s]++;
            if (out_valid[s] === 1'b1 && out_ready[s]) begin
                check("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_instance", s, e.s);
                    check("out_data", out_data[s], e.ct);
                    check("tx_p_sequence", txp_bits[s], e.pt);
                    check("strobe_count", sidx[s], DW);
`ifdef CIPHER_SER_PARITY_EN
                    check("ct_parity", ct_parity[s], ^e.ct);
`endif
                end
            end
            ov_prev[s] = out_valid[s];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [DW-1:0] d, input bit hold);
        bit ok;
        ok = 1'b0;
        tick();
        in_data[s]  = d;
        in_valid[s] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready[s]) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", ok, 1);
        tick();
        if (!hold || !ok) in_valid[s] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ta;
        int base;
        bit seen;
        for (int s = 0; s < NI; s++) begin
            rst_n[s] = 1'b0; in_valid[s] = 1'b0; in_data[s] = '0;
            out_ready[s] = 1'b1; k[s] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < NI; s++) begin
            check("rst_tx_en", tx_en[s], 0);
            check("rst_tx_p", tx_p[s], 0);
            check("rst_out_valid", out_valid[s], 0);
            check("rst_out_data", out_data[s], 0);
            check("rst_busy", busy[s], 0);
            check("rst_in_ready", in_ready[s], 0);
`ifdef CIPHER_SER_PARITY_EN
            check("rst_ct_parity", ct_parity[s], 0);
`endif
        end
        tick();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready0", in_ready[0], 1);
        check("post_rst_in_ready1", in_ready[1], 1);

        // Identity keystream, GAP=1.
        k[0] = 1'b0;
        send(0, 8'hF0, 1'b0);
        wait_drain();

        // Inverting keystream, GAP=0.
        k[1] = 1'b1;
        send(1, 8'hA5, 1'b0);
        wait_drain();

        // Output backpressure.
        out_ready[0] = 1'b0;
        send(0, 8'h3C, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_out_valid_timeout", seen, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid_held", out_valid[0], 1);
            check("bp_out_data_held", out_data[0], 8'h3C);
            check("bp_in_ready_low", in_ready[0], 0);
            check("bp_busy", busy[0], 1);
            @(negedge clk);
        end
        tick();
        out_ready[0] = 1'b1;
        tick();
        @(negedge clk);
        check("bp_in_ready_after", in_ready[0], 1);
        check("bp_out_valid_after", out_valid[0], 0);
        check("bp_sb_empty", sb.size(), 0);

        // Back-to-back with in_valid held high, both gap settings.
        send(0, 8'h01, 1'b1);
        ta = t0[0];
        send(0, 8'h80, 1'b0);
        check("b2b_accept_gap_g1", t0[0] - ta, DW * 2 - 1 + 3);
        wait_drain();
        k[1] = 1'b0;
        send(1, 8'h01, 1'b1);
        ta = t0[1];
        send(1, 8'h80, 1'b0);
        check("b2b_accept_gap_g0", t0[1] - ta, DW + 3);
        wait_drain();

        // Reset in the middle of a word (GAP=0 keeps strobing until reset lands).
        send(1, 8'hC3, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (sidx[1] >= 3) break;
            tick();
        end
        check("midrst_third_strobe", sidx[1] >= 3, 1);
        rst_n[1] = 1'b0;
        @(negedge clk);
        check("midrst_in_ready_low", in_ready[1], 0);
        tick();
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("midrst_tx_en", tx_en[1], 0);
        check("midrst_busy", busy[1], 0);
        check("midrst_out_valid", out_valid[1], 0);
        check("midrst_in_ready", in_ready[1], 1);
        base = ov_count[1];
        repeat (15) @(negedge clk);
        check("midrst_no_output", ov_count[1] - base, 0);
        send(1, 8'h55, 1'b0);
        wait_drain();

        repeat (3) tick();
        check("sb_final_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
